// File: rtl/micro_sequencer_pkg.sv
// Shared constants and types for the micro-sequencer front end.
package micro_sequencer_pkg;

  localparam int UPC_WIDTH          = 10;
  localparam int MBRANCH_ADDR_WIDTH = UPC_WIDTH;
  localparam int UINSTR_WIDTH       = 44;
  localparam int CPU_STATES         = 6;
  localparam int STATE_WIDTH        = $clog2(CPU_STATES);

  localparam logic [UPC_WIDTH-1:0] RESET_UPC_DEFAULT = 10'd0;

  // Externally visible cpu_state encoding; downstream stages decode these codes.
  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DECODE   = 3'd2,
    ST_EXECUTE1 = 3'd3,
    ST_EXECUTE2 = 3'd4,
    ST_HALT     = 3'd5
  } cpu_state_e;

  // Next-uPC source selection.
  typedef enum logic [1:0] {
    UPC_HOLD   = 2'd0,
    UPC_INCR   = 2'd1,
    UPC_BRANCH = 2'd2
  } upc_sel_e;

endpackage

// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer, the micro-ROM and the decode stages.
interface micro_sequencer_if;
  import micro_sequencer_pkg::*;

  logic                     start;
  logic                     stall;
  logic                     is_branch;
  logic                     branch_cond;
  logic                     halt_req;
  logic [UPC_WIDTH-1:0]     mbranch_target;
  logic [UINSTR_WIDTH-1:0]  urom_rdata;
  logic                     urom_en;
  logic [UPC_WIDTH-1:0]     urom_addr;
  logic [STATE_WIDTH-1:0]   cpu_state;
  logic [UPC_WIDTH-1:0]     upc;
  logic [UINSTR_WIDTH-1:0]  uinstr;
  logic                     uinstr_valid;
  logic                     busy;
  logic                     done;

  // Sequencer side.
  modport master (
    input  start, stall, is_branch, branch_cond, halt_req, mbranch_target, urom_rdata,
    output urom_en, urom_addr, cpu_state, upc, uinstr, uinstr_valid, busy, done
  );

  // ROM / decode / control side.
  modport slave (
    output start, stall, is_branch, branch_cond, halt_req, mbranch_target, urom_rdata,
    input  urom_en, urom_addr, cpu_state, upc, uinstr, uinstr_valid, busy, done
  );

endinterface

// File: rtl/micro_sequencer_upc_next.sv
// Next micro-PC selection: hold, increment with natural wrap, or branch target.
module micro_sequencer_upc_next
  import micro_sequencer_pkg::*;
(
  input  logic [UPC_WIDTH-1:0] upc_i,
  input  logic [UPC_WIDTH-1:0] target_i,
  input  upc_sel_e             sel_i,
  output logic [UPC_WIDTH-1:0] upc_next_o
);

  localparam logic [UPC_WIDTH-1:0] UPC_ONE = UPC_WIDTH'(1);

  // Pick the next uPC; the increment wraps 1023 -> 0 by truncation.
  always_comb begin
    upc_next_o = upc_i;
    case (sel_i)
      UPC_HOLD:   upc_next_o = upc_i;
      UPC_INCR:   upc_next_o = upc_i + UPC_ONE;
      UPC_BRANCH: upc_next_o = target_i;
      default:    upc_next_o = upc_i;
    endcase
  end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-sequencer: owns the uPC, the cpu_state FSM and the instruction register.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter logic [UPC_WIDTH-1:0] RESET_UPC = RESET_UPC_DEFAULT
) (
  input  logic               sys_clk,
  input  logic               sys_reset,
  micro_sequencer_if.master  bus
);

  cpu_state_e               state_q, state_d;
  logic [UPC_WIDTH-1:0]     upc_q, upc_d, upc_calc_s;
  upc_sel_e                 upc_sel_s;
  logic                     load_reset_s;
  logic [UINSTR_WIDTH-1:0]  uinstr_q, uinstr_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  micro_sequencer_upc_next u_upc_next (
    .upc_i      (upc_q),
    .target_i   (bus.mbranch_target),
    .sel_i      (upc_sel_s),
    .upc_next_o (upc_calc_s)
  );

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE or HALT.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE:     state_d = bus.start ? ST_FETCH : ST_IDLE;
      ST_FETCH:    state_d = ST_DECODE;
      ST_DECODE:   state_d = ST_EXECUTE1;
      ST_EXECUTE1: state_d = ST_EXECUTE2;
      ST_EXECUTE2: begin
        if (bus.stall) begin
          state_d = ST_EXECUTE2;
        end else if (bus.halt_req) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT:     state_d = bus.start ? ST_FETCH : ST_HALT;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from state and inputs.
  always_comb begin
    upc_sel_s    = UPC_HOLD;
    load_reset_s = 1'b0;
    uinstr_d     = uinstr_q;
    valid_d      = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        load_reset_s = bus.start;
      end
      ST_DECODE: begin
        uinstr_d = bus.urom_rdata;
        valid_d  = 1'b1;
      end
      ST_EXECUTE2: begin
        if (bus.stall || bus.halt_req) begin
          upc_sel_s = UPC_HOLD;
        end else if (bus.is_branch && bus.branch_cond) begin
          upc_sel_s = UPC_BRANCH;
        end else begin
          upc_sel_s = UPC_INCR;
        end
      end
      default: begin
        upc_sel_s = UPC_HOLD;
      end
    endcase
    upc_d  = load_reset_s ? RESET_UPC : upc_calc_s;
    busy_d = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
             (state_d == ST_EXECUTE1) || (state_d == ST_EXECUTE2);
    done_d = (state_d == ST_HALT);
  end

  // Output and datapath registers.
  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      upc_q    <= RESET_UPC;
      uinstr_q <= {UINSTR_WIDTH{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      upc_q    <= upc_d;
      uinstr_q <= uinstr_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // ROM port is decoded straight from state so the read issues in FETCH itself.
  assign bus.urom_en      = (state_q == ST_FETCH);
  assign bus.urom_addr    = upc_q;
  assign bus.cpu_state    = state_q;
  assign bus.upc          = upc_q;
  assign bus.uinstr       = uinstr_q;
  assign bus.uinstr_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed bench for micro_sequencer: instruction-level model plus literal pins.
module tb_micro_sequencer;

  logic sys_clk;
  logic sys_reset;

  micro_sequencer_if bus ();

  micro_sequencer dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  localparam logic [43:0] ROM0_LIT = {4'hA, 10'h000, 10'h3C5, 10'h000, 10'h155};

  // Distinct content per address.
  function automatic logic [43:0] rom_word(input logic [9:0] a);
    return {4'hA, a, 10'h3C5 ^ a, a, 10'h155};
  endfunction

  // Synchronous ROM with one cycle of read latency.
  always @(posedge sys_clk) begin
    if (bus.urom_en === 1'b1) bus.urom_rdata <= rom_word(bus.urom_addr);
  end

  int n_vec = 0;
  int n_err = 0;

  // Model state (instruction level).
  logic [9:0]  m_upc;
  logic [43:0] m_uinstr;

  // Expected outputs for the current cycle.
  bit          exp_on;
  logic [2:0]  exp_state;
  logic [9:0]  exp_upc;
  logic        exp_en;
  logic [9:0]  exp_addr;
  logic [43:0] exp_uinstr;
  logic        exp_valid;
  logic        exp_busy;
  logic        exp_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Compare every cycle, half a period after the active edge.
  always @(negedge sys_clk) begin
    if (exp_on) begin
      chk("cpu_state",    64'(bus.cpu_state),    64'(exp_state));
      chk("upc",          64'(bus.upc),          64'(exp_upc));
      chk("urom_en",      64'(bus.urom_en),      64'(exp_en));
      chk("urom_addr",    64'(bus.urom_addr),    64'(exp_addr));
      chk("uinstr",       64'(bus.uinstr),       64'(exp_uinstr));
      chk("uinstr_valid", 64'(bus.uinstr_valid), 64'(exp_valid));
      chk("busy",         64'(bus.busy),         64'(exp_busy));
      chk("done",         64'(bus.done),         64'(exp_done));
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_exp(input logic [2:0] st, input logic en, input logic vld,
                         input logic bsy, input logic dn);
    exp_state  = st;
    exp_upc    = m_upc;
    exp_en     = en;
    exp_addr   = m_upc;
    exp_uinstr = m_uinstr;
    exp_valid  = vld;
    exp_busy   = bsy;
    exp_done   = dn;
  endtask

  task automatic clear_ex_inputs();
    bus.stall          = 1'b0;
    bus.halt_req       = 1'b0;
    bus.is_branch      = 1'b0;
    bus.branch_cond    = 1'b0;
    bus.mbranch_target = 10'd0;
  endtask

  // One cycle in IDLE (code 0) or HALT (code 5); start restarts at uPC 0.
  task automatic hold_cyc(input logic [2:0] code, input bit st);
    step();
    set_exp(code, 1'b0, 1'b0, 1'b0, (code == 3'd5));
    clear_ex_inputs();
    bus.start = st;
    if (st) m_upc = 10'd0;
  endtask

  // One micro-instruction from FETCH to the end of EXECUTE2.
  task automatic instr(input int stall_n, input bit halt, input bit br, input bit cond,
                       input logic [9:0] tgt, input int lit_addr, input bit start_dec,
                       input bit abort_ex1);
    // FETCH
    step();
    set_exp(3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.start = 1'b0;
    clear_ex_inputs();
    if (lit_addr >= 0) chk("fetch_addr_lit", 64'(bus.urom_addr), 64'(lit_addr));
    // DECODE
    step();
    set_exp(3'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.start = start_dec;
    m_uinstr = rom_word(m_upc);
    // EXECUTE1
    step();
    bus.start = 1'b0;
    if (abort_ex1) begin
      sys_reset = 1'b0;
      #1;
      chk("abort_state",  64'(bus.cpu_state),    64'd0);
      chk("abort_upc",    64'(bus.upc),          64'd0);
      chk("abort_uinstr", 64'(bus.uinstr),       64'd0);
      chk("abort_valid",  64'(bus.uinstr_valid), 64'd0);
      chk("abort_busy",   64'(bus.busy),         64'd0);
      m_upc    = 10'd0;
      m_uinstr = 44'd0;
      set_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      return;
    end
    set_exp(3'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    if (m_upc == 10'd0) chk("rom0_lit", 64'(bus.uinstr), 64'(ROM0_LIT));
    // EXECUTE2, with stall cycles carrying decoy branch/halt inputs
    for (int k = 0; k <= stall_n; k++) begin
      step();
      set_exp(3'd4, 1'b0, 1'b0, 1'b1, 1'b0);
      if (k < stall_n) begin
        bus.stall          = 1'b1;
        bus.halt_req       = 1'b1;
        bus.is_branch      = 1'b1;
        bus.branch_cond    = 1'b1;
        bus.mbranch_target = 10'h3FF;
      end else begin
        bus.stall          = 1'b0;
        bus.halt_req       = halt;
        bus.is_branch      = br;
        bus.branch_cond    = cond;
        bus.mbranch_target = tgt;
      end
    end
    if (halt)             m_upc = m_upc;
    else if (br && cond)  m_upc = tgt;
    else                  m_upc = 10'((int'(m_upc) + 1) % 1024);
  endtask

  initial begin
    exp_on    = 1'b0;
    sys_reset = 1'b0;
    bus.start = 1'b0;
    clear_ex_inputs();
    m_upc     = 10'd0;
    m_uinstr  = 44'd0;

    // Reset state
    repeat (2) @(posedge sys_clk);
    #1;
    set_exp(3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_on = 1'b1;
    chk("rst_state",   64'(bus.cpu_state), 64'd0);
    chk("rst_urom_en", 64'(bus.urom_en),   64'd0);
    chk("rst_done",    64'(bus.done),      64'd0);
    sys_reset = 1'b1;

    hold_cyc(3'd0, 1'b0);
    hold_cyc(3'd0, 1'b0);
    hold_cyc(3'd0, 1'b1);

    // Straight-line run 0..4
    instr(0, 0, 0, 0, 10'd0, 0, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 1, 0, 0);
    instr(0, 0, 1, 0, 10'h155, 2, 0, 0);
    instr(0, 0, 0, 1, 10'h155, 3, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 4, 0, 0);
    // Taken branch at 5, branch back to 5, then not-taken
    instr(0, 0, 1, 1, 10'h2A0, 5, 0, 0);
    instr(0, 0, 1, 1, 10'd5, 10'h2A0, 0, 0);
    instr(0, 0, 1, 0, 10'h2A0, 5, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 6, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 7, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 8, 0, 0);
    // Seven stall cycles at 9
    instr(7, 0, 0, 0, 10'd0, 9, 0, 0);
    chk("stall_upc_lit", 64'(bus.upc), 64'd9);
    // Wrap 1023 -> 0, then halt at 12
    instr(0, 0, 1, 1, 10'd1023, 10, 0, 0);
    instr(0, 0, 0, 0, 10'd0, 1023, 0, 0);
    instr(0, 0, 1, 1, 10'd12, 0, 0, 0);
    instr(0, 1, 1, 1, 10'd40, 12, 0, 0);
    hold_cyc(3'd5, 1'b0);
    chk("halt_done_lit", 64'(bus.done),      64'd1);
    chk("halt_busy_lit", 64'(bus.busy),      64'd0);
    chk("halt_upc_lit",  64'(bus.upc),       64'd12);
    chk("halt_st_lit",   64'(bus.cpu_state), 64'd5);
    hold_cyc(3'd5, 1'b0);
    hold_cyc(3'd5, 1'b1);
    // Restart at 0 with start pulsed in DECODE
    instr(0, 0, 0, 0, 10'd0, 0, 1, 0);
    // Reset in EXECUTE1 of the instruction at 1
    instr(0, 0, 0, 0, 10'd0, 1, 0, 1);
    hold_cyc(3'd0, 1'b0);
    sys_reset = 1'b1;
    hold_cyc(3'd0, 1'b0);
    hold_cyc(3'd0, 1'b0);
    hold_cyc(3'd0, 1'b0);
    chk("post_rst_idle_lit", 64'(bus.cpu_state), 64'd0);
    @(negedge sys_clk);
    #1;
    exp_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
